hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Multi-cycle sequencer for the HI/LO pair: runs a radix-2 restoring division for DIV/DIVU, one quotient bit per cycle.
- Sits beside the EX stage. Stalls the pipeline while busy.
- On completion, presents remainder/quotient on hi_o/lo_o with a one-cycle hilo_we_o write strobe for the HI/LO register file.

Parameters:
- WIDTH, 32, operand/result width. Step counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (rst==0 resets)
- start_i  in  1  divide request from EX; level, held until ready_o seen
- signed_i  in  1  1=DIV (two's complement), 0=DIVU; sampled at accept
- opdata1_i  in  WIDTH  dividend; sampled at accept
- opdata2_i  in  WIDTH  divisor; sampled at accept
- annul_i  in  1  cancel (flush/exception); aborts any in-flight operation
- stallreq_o  out  1  pipeline stall request (combinational)
- ready_o  out  1  result valid (registered)
- hi_o  out  WIDTH  remainder (registered)
- lo_o  out  WIDTH  quotient (registered)
- hilo_we_o  out  1  one-cycle HI/LO write strobe (registered)

Behaviour:
- Reset (rst==0, asynchronous): state=IDLE; hi_o, lo_o, counter, working regs = 0; hilo_we_o=0; ready_o=0. Reset mid-operation discards all work.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - start_i=1 & annul_i=0 & opdata2_i==0 -> DIVZERO.
  - start_i=1 & annul_i=0 & opdata2_i!=0 -> BUSY. Latch |dividend|, |divisor| (abs only if signed_i), sign flags, counter=0, partial remainder=0.
- BUSY, one step per cycle:
  - shift {rem,quo} left 1; trial = rem - divisor (WIDTH+1 bits).
  - trial >= 0: rem=trial, quo[0]=1; else quo[0]=0.
  - counter increments; after WIDTH steps -> DONE.
- DIVZERO: one cycle -> DONE with result hi=opdata1 (latched), lo={WIDTH{1'b1}}.
- DONE entry (registered):
  - signed: lo = -quo if dividend sign != divisor sign; hi = -rem if dividend negative; otherwise raw values.
  - hilo_we_o=1 for exactly the entry cycle; ready_o=1 throughout DONE.
  - Stay in DONE while start_i=1; start_i=0 -> IDLE, ready_o=0.
  - hi_o/lo_o hold their last value until the next DONE entry.
- Latency (accept cycle = T): BUSY T+1..T+WIDTH; DONE and hilo_we_o at T+WIDTH+1. Divide-by-zero: DONE at T+2.
- stallreq_o = (IDLE & start_i & !annul_i) | BUSY | DIVZERO. It is 0 in DONE, so the instruction advances.
- annul_i=1 in any state except reset -> IDLE next cycle. No hilo_we_o; hi_o/lo_o unchanged; ready_o=0. annul_i overrides start_i in IDLE. If annul_i coincides with the DONE-entry edge, the write is suppressed.
- Overflow: signed MIN/-1 -> lo=MIN (wraps), hi=0. No trap.
- start_i re-asserted in the same cycle as the DONE->IDLE transition is not accepted until IDLE.

Optional Feature:
- Macro: HILO_DIV_ZERO_EXC_EN.
- Defined:
  - adds output div_zero_o (1 bit, registered, reset 0), pulsed with DONE entry after DIVZERO.
  - hilo_we_o suppressed for divide-by-zero; hi_o/lo_o unchanged.
- Undefined: no div_zero_o port; divide-by-zero writes hi=dividend, lo=all ones as above.

Test Plan:
- DIVU 100/7 accepted at T -> stallreq_o=1 T..T+32; at T+33 hilo_we_o=1 (single cycle), lo_o=14, hi_o=2, ready_o=1 until start_i drops.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> lo_o=0xFFFFFFFD, hi_o=1.
- DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, no error. DIVU 0xFFFFFFFF/1 -> lo_o=0xFFFFFFFF, hi_o=0.
- DIVU 5/0 -> DONE at T+2, hi_o=5, lo_o=0xFFFFFFFF, hilo_we_o=1. With HILO_DIV_ZERO_EXC_EN: div_zero_o=1, hilo_we_o=0, hi/lo unchanged.
- Annul at T+10 during BUSY -> IDLE at T+11, stallreq_o=0, hilo_we_o never asserted, hi_o/lo_o keep previous values. A new start_i is accepted next cycle.
- rst=0 asynchronously at T+20 -> all outputs 0 immediately. After release, DIVU 9/3 -> lo_o=3, hi_o=0 at accept+33.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// Radix-2 restoring DIV/DIVU sequencer for the HI/LO pair, one quotient bit per cycle.
// Optional macro HILO_DIV_ZERO_EXC_EN: flag divide-by-zero on div_zero_o instead of writing HI/LO.
module hilo_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             annul_i,
  output logic             stallreq_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             hilo_we_o
`ifdef HILO_DIV_ZERO_EXC_EN
  ,
  output logic             div_zero_o
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic             we_q, we_d, ready_q, ready_d;
`ifdef HILO_DIV_ZERO_EXC_EN
  logic             dz_q, dz_d;
`endif

  logic [WIDTH-1:0] abs1, abs2;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] trial;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  assign abs1 = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // Shifted partial remainder needs one extra bit before the trial subtract.
  assign sh     = {rem_q, quo_q[WIDTH-1]};
  assign trial  = {1'b0, sh} - {2'b00, dvs_q};
  assign ge     = ~trial[WIDTH+1];
  assign rem_nx = ge ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
  assign quo_nx = {quo_q[WIDTH-2:0], ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    we_d    = 1'b0;
    ready_d = ready_q;
`ifdef HILO_DIV_ZERO_EXC_EN
    dz_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          negq_d = signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          negr_d = signed_i && opdata1_i[WIDTH-1];
          dvs_d  = abs2;
          rem_d  = '0;
          cnt_d  = '0;
          if (opdata2_i == '0) begin
            // Raw dividend parked in the quotient register for the HI write.
            state_d = DIVZERO;
            quo_d   = opdata1_i;
          end else begin
            state_d = BUSY;
            quo_d   = abs1;
          end
        end
      end
      DIVZERO: begin
        state_d = DONE;
        ready_d = 1'b1;
`ifdef HILO_DIV_ZERO_EXC_EN
        dz_d    = 1'b1;
`else
        hi_d    = quo_q;
        lo_d    = '1;
        we_d    = 1'b1;
`endif
      end
      BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          hi_d    = negr_q ? -rem_nx : rem_nx;
          lo_d    = negq_q ? -quo_nx : quo_nx;
          we_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      DONE: begin
        if (!start_i) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (annul_i) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      we_d    = 1'b0;
      ready_d = 1'b0;
`ifdef HILO_DIV_ZERO_EXC_EN
      dz_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
`ifdef HILO_DIV_ZERO_EXC_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      we_q    <= we_d;
      ready_q <= ready_d;
`ifdef HILO_DIV_ZERO_EXC_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign stallreq_o = (state_q == IDLE && start_i && !annul_i) ||
                      (state_q == BUSY) || (state_q == DIVZERO);
  assign ready_o    = ready_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign hilo_we_o  = we_q;
`ifdef HILO_DIV_ZERO_EXC_EN
  assign div_zero_o = dz_q;
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: vector table of divides plus annul and async-reset sequences.
module tb_hilo_div_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start_i = 1'b0;
  logic         signed_i = 1'b0;
  logic         annul_i = 1'b0;
  logic [W-1:0] opdata1_i = '0;
  logic [W-1:0] opdata2_i = '0;
  logic         stallreq_o, ready_o, hilo_we_o;
  logic [W-1:0] hi_o, lo_o;
`ifdef HILO_DIV_ZERO_EXC_EN
  logic         div_zero_o;
`endif

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .hilo_we_o  (hilo_we_o)
`ifdef HILO_DIV_ZERO_EXC_EN
    ,
    .div_zero_o (div_zero_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] held_hi = '0;
  logic [W-1:0] held_lo = '0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           dz;
  } vec_t;

  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo, input bit dz,
                        input string tag);
    int  n;
    int  lat;
    bit  busy_ok;
    lat = dz ? 2 : W + 1;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    @(negedge clk);
    chk1({tag, "_stall_accept"}, stallreq_o, 1'b1);
    busy_ok = 1'b1;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (ready_o) break;
      if (!stallreq_o || hilo_we_o) busy_ok = 1'b0;
    end
    chk({tag, "_latency"}, W'(n), W'(lat));
    chk1({tag, "_busy_stall"}, busy_ok, 1'b1);
    chk1({tag, "_done_stall"}, stallreq_o, 1'b0);
`ifdef HILO_DIV_ZERO_EXC_EN
    if (dz) begin
      chk1({tag, "_dz_flag"}, div_zero_o, 1'b1);
      chk1({tag, "_we"}, hilo_we_o, 1'b0);
      chk({tag, "_hi"}, hi_o, held_hi);
      chk({tag, "_lo"}, lo_o, held_lo);
    end else begin
      chk1({tag, "_dz_flag"}, div_zero_o, 1'b0);
`else
    begin
`endif
      chk1({tag, "_we"}, hilo_we_o, 1'b1);
      chk({tag, "_hi"}, hi_o, ehi);
      chk({tag, "_lo"}, lo_o, elo);
      held_hi = ehi;
      held_lo = elo;
    end
    @(negedge clk);
    chk1({tag, "_we_single"}, hilo_we_o, 1'b0);
    chk1({tag, "_ready_hold"}, ready_o, 1'b1);
`ifdef HILO_DIV_ZERO_EXC_EN
    chk1({tag, "_dz_single"}, div_zero_o, 1'b0);
`endif
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk1({tag, "_ready_drop"}, ready_o, 1'b0);
    chk({tag, "_hi_held"}, hi_o, held_hi);
    chk({tag, "_lo_held"}, lo_o, held_lo);
  endtask

  vec_t vecs [9];

  initial begin
    bit we_seen;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  1'b0};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[5] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFF2,  1'b0};
    vecs[6] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFF2,  1'b0};
    vecs[7] = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  1'b1};
    vecs[8] = '{1'b0, 32'hFFFF_FFF0,  32'd16,         32'd0,          32'h0FFF_FFFF,  1'b0};

    #2;
    chk1("rst_ready", ready_o, 1'b0);
    chk1("rst_we", hilo_we_o, 1'b0);
    chk1("rst_stall", stallreq_o, 1'b0);
    chk("rst_hi", hi_o, '0);
    chk("rst_lo", lo_o, '0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++)
      do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
             $sformatf("v%0d", i));

    // Annul during BUSY at T+10.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd10;
    for (int k = 0; k < 10; k++) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk1("annul_busy_stall", stallreq_o, 1'b1);
    @(posedge clk); #1;
    annul_i = 1'b0;
    @(negedge clk);
    chk1("annul_idle_stall", stallreq_o, 1'b0);
    chk1("annul_ready", ready_o, 1'b0);
    chk("annul_hi", hi_o, held_hi);
    chk("annul_lo", lo_o, held_lo);
    we_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hilo_we_o || ready_o) we_seen = 1'b1;
    end
    chk1("annul_no_write", we_seen, 1'b0);
    do_div(1'b0, 32'd81, 32'd9, 32'd0, 32'd9, 1'b0, "post_annul");

    // Annul coinciding with the DONE-entry edge.
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd3;
    for (int k = 0; k < 32; k++) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    chk1("annul_edge_stall", stallreq_o, 1'b1);
    @(posedge clk); #1;
    annul_i = 1'b0;
    @(negedge clk);
    chk1("annul_edge_we", hilo_we_o, 1'b0);
    chk1("annul_edge_ready", ready_o, 1'b0);
    chk("annul_edge_hi", hi_o, held_hi);
    chk("annul_edge_lo", lo_o, held_lo);

    // Annul overrides start in IDLE.
    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7;
    @(negedge clk);
    chk1("annul_idle_override", stallreq_o, 1'b0);
    @(negedge clk);
    chk1("annul_idle_still", stallreq_o, 1'b0);
    chk1("annul_idle_ready", ready_o, 1'b0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;

    // Asynchronous reset mid-operation at T+20.
    do_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "pre_rst");
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd5;
    for (int k = 0; k < 20; k++) @(posedge clk);
    #3;
    rst = 1'b0; start_i = 1'b0;
    #1;
    chk("arst_hi", hi_o, '0);
    chk("arst_lo", lo_o, '0);
    chk1("arst_ready", ready_o, 1'b0);
    chk1("arst_stall", stallreq_o, 1'b0);
    chk1("arst_we", hilo_we_o, 1'b0);
    held_hi = '0;
    held_lo = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
